// File: rtl/vc_arbiter.sv
// Weighted round-robin pop scheduler for two virtual-channel FIFOs.
// Each VC gets a burst of up to its weight in pops per turn; all pops stop while a destination pauses.
module vc_arbiter #(
    parameter int LENGTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [LENGTH-1:0] Peso_VC0_prob,
    input  logic [LENGTH-1:0] Peso_VC1_prob,
    input  logic              VC0_empty,
    input  logic              VC1_empty,
    input  logic              D0_pause,
    input  logic              D1_pause,
    output logic              pop_VC0,
    output logic              pop_VC1,
    output logic [1:0]        arb_state,
    output logic [LENGTH-1:0] burst_cnt,
    output logic              last_vc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SRV0 = 2'd1,
        SRV1 = 2'd2
    } state_t;

    state_t            state_reg;
    logic [LENGTH-1:0] burst_cnt_reg;
    logic              last_vc_reg;
    logic [LENGTH-1:0] weight_reg [2];

    logic [LENGTH-1:0] peso [2];
    logic [LENGTH-1:0] weight_load [2];
    logic [1:0]        vc_empty;
    logic [1:0]        serving;
    logic [1:0]        pop;
    logic              blocked;
    logic              cur_vc;
    logic              other_vc;
    logic              idle_pick;
    logic [LENGTH:0]   burst_inc;
    logic              burst_done;

    assign peso[0]  = Peso_VC0_prob;
    assign peso[1]  = Peso_VC1_prob;
    assign vc_empty = {VC1_empty, VC0_empty};
    assign blocked  = D0_pause | D1_pause;
    assign serving  = {state_reg == SRV1, state_reg == SRV0};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_vc
            // A zero weight would starve the VC forever, so it is promoted to one pop per turn.
            assign weight_load[gi] = (peso[gi] == '0) ? LENGTH'(1) : peso[gi];
            assign pop[gi] = serving[gi] & ~blocked & ~vc_empty[gi] & ~reset & ~init;
        end
    endgenerate

    assign cur_vc     = (state_reg == SRV1);
    assign other_vc   = ~cur_vc;
    assign burst_inc  = {1'b0, burst_cnt_reg} + {{LENGTH{1'b0}}, 1'b1};
    assign burst_done = (burst_inc == {1'b0, weight_reg[cur_vc]});
    // Prefer the VC that did not own the last turn; fall back to whichever one has data.
    assign idle_pick  = vc_empty[~last_vc_reg] ? last_vc_reg : ~last_vc_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            burst_cnt_reg <= '0;
            last_vc_reg   <= 1'b1;
            for (int i = 0; i < 2; i++) weight_reg[i] <= LENGTH'(1);
        end else if (init) begin
            state_reg     <= IDLE;
            burst_cnt_reg <= '0;
            for (int i = 0; i < 2; i++) weight_reg[i] <= weight_load[i];
        end else begin
            case (state_reg)
                SRV0, SRV1: begin
                    if (!blocked) begin
                        if (vc_empty[cur_vc]) begin
                            burst_cnt_reg <= '0;
                            if (!vc_empty[other_vc]) begin
                                state_reg   <= other_vc ? SRV1 : SRV0;
                                last_vc_reg <= other_vc;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end else if (burst_done) begin
                            // Back-to-back handover; with nobody waiting the same VC starts a fresh burst.
                            burst_cnt_reg <= '0;
                            if (!vc_empty[other_vc]) begin
                                state_reg   <= other_vc ? SRV1 : SRV0;
                                last_vc_reg <= other_vc;
                            end
                        end else begin
                            burst_cnt_reg <= burst_inc[LENGTH-1:0];
                        end
                    end
                end
                default: begin
                    if (vc_empty != 2'b11) begin
                        state_reg     <= idle_pick ? SRV1 : SRV0;
                        last_vc_reg   <= idle_pick;
                        burst_cnt_reg <= '0;
                    end
                end
            endcase
        end
    end

    assign pop_VC0   = pop[0];
    assign pop_VC1   = pop[1];
    assign arb_state = state_reg;
    assign burst_cnt = burst_cnt_reg;
    assign last_vc   = last_vc_reg;

endmodule

// File: tb/tb_vc_arbiter.sv
// Bench for vc_arbiter: per-cycle vector table plus FIFO-backed alternation sequences,
// with expected outputs queued when stimulus is driven and checked when the DUT responds.
module tb_vc_arbiter;

    logic       clk = 1'b0;
    logic       reset, init;
    logic [3:0] Peso_VC0_prob, Peso_VC1_prob;
    logic       VC0_empty, VC1_empty, D0_pause, D1_pause;
    logic       pop_VC0, pop_VC1;
    logic [1:0] arb_state;
    logic [3:0] burst_cnt;
    logic       last_vc;

    int total = 0;
    int bad   = 0;

    vc_arbiter #(.LENGTH(4)) dut (
        .clk(clk), .reset(reset), .init(init),
        .Peso_VC0_prob(Peso_VC0_prob), .Peso_VC1_prob(Peso_VC1_prob),
        .VC0_empty(VC0_empty), .VC1_empty(VC1_empty),
        .D0_pause(D0_pause), .D1_pause(D1_pause),
        .pop_VC0(pop_VC0), .pop_VC1(pop_VC1),
        .arb_state(arb_state), .burst_cnt(burst_cnt), .last_vc(last_vc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, i;
        logic [3:0] p0, p1;
        logic       e0, e1, d0, d1;
        logic       x0, x1;
        logic [1:0] st;
        logic [3:0] b;
        logic       l;
    } vec_t;

    vec_t       vecs [$];
    logic [8:0] exp_q [$];
    int         exp_vc_q [$];

    task automatic add(input logic r, i, input int p0, p1, input logic e0, e1, d0, d1,
                       input logic x0, x1, input int st, b, input logic l);
        vec_t v;
        v.r = r; v.i = i; v.p0 = 4'(p0); v.p1 = 4'(p1);
        v.e0 = e0; v.e1 = e1; v.d0 = d0; v.d1 = d1;
        v.x0 = x0; v.x1 = x1; v.st = 2'(st); v.b = 4'(b); v.l = l;
        vecs.push_back(v);
    endtask

    task automatic check_inv(input string tag);
        total++;
        if ((pop_VC0 && VC0_empty) || (pop_VC1 && VC1_empty) || (pop_VC0 && pop_VC1) ||
            ((pop_VC0 || pop_VC1) && (D0_pause || D1_pause || reset || init))) begin
            bad++;
            $display("FAIL inv_%s got pops=%b%b empty=%b%b pause=%b%b required legal pops",
                     tag, pop_VC0, pop_VC1, VC0_empty, VC1_empty, D0_pause, D1_pause);
        end
    endtask

    task automatic apply(input int idx);
        vec_t       v;
        logic [8:0] got, want;
        v = vecs[idx];
        @(posedge clk); #1;
        reset = v.r; init = v.i; Peso_VC0_prob = v.p0; Peso_VC1_prob = v.p1;
        VC0_empty = v.e0; VC1_empty = v.e1; D0_pause = v.d0; D1_pause = v.d1;
        exp_q.push_back({v.x0, v.x1, v.st, v.b, v.l});
        @(negedge clk);
        got  = {pop_VC0, pop_VC1, arb_state, burst_cnt, last_vc};
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL vec%0d got pops/state/cnt/last=%b required %b", idx, got, want);
        end else begin
            $display("vec%0d ok pops=%b%b state=%0d cnt=%0d last=%0d",
                     idx, pop_VC0, pop_VC1, arb_state, burst_cnt, last_vc);
        end
        check_inv($sformatf("vec%0d", idx));
    endtask

    // Three entries per VC in a behavioural FIFO; empty flags update the cycle after a pop.
    task automatic run_seq(input string name, input logic use_init, input int p0, p1);
        int cnt0, cnt1, first_pop, cyc;
        @(posedge clk); #1;
        reset = ~use_init; init = use_init;
        Peso_VC0_prob = 4'(p0); Peso_VC1_prob = 4'(p1);
        VC0_empty = 1'b0; VC1_empty = 1'b0; D0_pause = 1'b0; D1_pause = 1'b0;
        cnt0 = 3; cnt1 = 3; first_pop = -1;
        exp_vc_q = {0, 1, 0, 1, 0, 1};
        @(negedge clk);
        check_inv({name, "_start"});
        @(posedge clk); #1;
        reset = 1'b0; init = 1'b0;
        for (cyc = 0; cyc < 30; cyc++) begin
            VC0_empty = (cnt0 == 0);
            VC1_empty = (cnt1 == 0);
            @(negedge clk);
            check_inv(name);
            if (pop_VC0 || pop_VC1) begin
                total++;
                if (exp_vc_q.size() == 0 || exp_vc_q[0] != (pop_VC1 ? 1 : 0)) begin
                    bad++;
                    $display("FAIL %s_order cyc%0d got vc%0d required vc%0d", name, cyc,
                             pop_VC1 ? 1 : 0, (exp_vc_q.size() == 0) ? -1 : exp_vc_q[0]);
                end else begin
                    $display("%s cyc%0d pop vc%0d ok", name, cyc, exp_vc_q[0]);
                end
                if (exp_vc_q.size() != 0) void'(exp_vc_q.pop_front());
                if (first_pop < 0) first_pop = cyc;
                if (pop_VC0 && cnt0 > 0) cnt0--;
                if (pop_VC1 && cnt1 > 0) cnt1--;
            end
            @(posedge clk); #1;
        end
        total++;
        if (exp_vc_q.size() != 0) begin
            bad++;
            $display("FAIL %s_done got %0d pops outstanding required 0", name, exp_vc_q.size());
        end
        total++;
        if (first_pop != 1) begin
            bad++;
            $display("FAIL %s_latency got first pop at cycle %0d required 1", name, first_pop);
        end
        total++;
        if (arb_state !== 2'd0) begin
            bad++;
            $display("FAIL %s_final_state got %0d required 0", name, arb_state);
        end
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; Peso_VC0_prob = '0; Peso_VC1_prob = '0;
        VC0_empty = 1'b0; VC1_empty = 1'b0; D0_pause = 1'b0; D1_pause = 1'b0;

        //   r  i  p0 p1 e0 e1 d0 d1  x0 x1 st b  l
        add(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        add(0, 1, 3, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        add(0, 0, 3, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        add(0, 0, 3, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0);
        add(0, 0, 3, 1, 0, 0, 0, 0,  1, 0, 1, 1, 0);
        add(0, 0, 3, 1, 0, 0, 0, 0,  1, 0, 1, 2, 0);
        add(0, 0, 3, 1, 0, 0, 0, 0,  0, 1, 2, 0, 1);
        add(0, 0, 3, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0);
        add(0, 0, 3, 1, 0, 0, 0, 0,  1, 0, 1, 1, 0);
        add(0, 0, 3, 1, 0, 0, 0, 0,  1, 0, 1, 2, 0);
        add(0, 0, 3, 1, 0, 0, 0, 0,  0, 1, 2, 0, 1);
        add(0, 1, 2, 1, 0, 1, 0, 0,  0, 0, 1, 0, 0);
        add(0, 0, 2, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0);
        add(0, 0, 2, 1, 0, 1, 0, 0,  1, 0, 1, 0, 0);
        add(0, 0, 2, 1, 0, 1, 0, 0,  1, 0, 1, 1, 0);
        add(0, 0, 2, 1, 0, 1, 0, 0,  1, 0, 1, 0, 0);
        add(0, 0, 2, 1, 0, 1, 0, 0,  1, 0, 1, 1, 0);
        add(0, 1, 4, 1, 0, 1, 0, 0,  0, 0, 1, 0, 0);
        add(0, 0, 4, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0);
        add(0, 0, 4, 1, 0, 1, 0, 0,  1, 0, 1, 0, 0);
        add(0, 0, 4, 1, 0, 1, 0, 0,  1, 0, 1, 1, 0);
        add(0, 0, 4, 1, 0, 1, 0, 1,  0, 0, 1, 2, 0);
        add(0, 0, 4, 1, 1, 1, 0, 1,  0, 0, 1, 2, 0);
        add(0, 0, 4, 1, 0, 1, 1, 1,  0, 0, 1, 2, 0);
        add(0, 0, 4, 1, 0, 1, 0, 0,  1, 0, 1, 2, 0);
        add(0, 0, 4, 1, 0, 1, 0, 0,  1, 0, 1, 3, 0);
        add(0, 0, 4, 1, 0, 1, 0, 0,  1, 0, 1, 0, 0);
        add(0, 1, 1, 2, 0, 0, 0, 0,  0, 0, 1, 1, 0);
        add(0, 0, 1, 2, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        add(0, 0, 1, 2, 0, 0, 0, 0,  0, 1, 2, 0, 1);
        add(0, 1, 1, 2, 0, 0, 0, 0,  0, 0, 2, 1, 1);
        add(0, 0, 1, 2, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        add(0, 0, 1, 2, 0, 0, 0, 0,  1, 0, 1, 0, 0);
        add(0, 0, 1, 2, 0, 0, 0, 0,  0, 1, 2, 0, 1);
        add(1, 0, 1, 2, 0, 0, 0, 0,  0, 0, 2, 1, 1);
        add(0, 0, 1, 2, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        add(0, 0, 1, 2, 0, 0, 0, 0,  1, 0, 1, 0, 0);
        add(0, 0, 1, 2, 0, 0, 0, 0,  0, 1, 2, 0, 1);
        add(0, 0, 1, 2, 1, 0, 0, 0,  0, 0, 1, 0, 0);
        add(0, 0, 1, 2, 1, 1, 0, 0,  0, 0, 2, 0, 1);
        add(0, 0, 1, 2, 1, 1, 0, 0,  0, 0, 0, 0, 1);
        add(0, 0, 1, 2, 1, 0, 0, 0,  0, 0, 0, 0, 1);
        add(0, 0, 1, 2, 1, 0, 0, 0,  0, 1, 2, 0, 1);
        add(0, 0, 1, 2, 1, 0, 1, 0,  0, 0, 2, 0, 1);

        repeat (2) @(posedge clk);
        for (int k = 0; k < vecs.size(); k++) apply(k);

        run_seq("alt_reset", 1'b0, 0, 0);
        run_seq("alt_zero_weights", 1'b1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
